pipelined_main_memory: RTL

Parametrised single-port main memory with a valid/ready request interface, byte-lane write strobes, configurable read latency, address checking, and an optional zero-fill sequence after reset. Acts as the unified instruction/data store behind the fetch and load/store stages. Addresses are byte addresses, converted internally to word indices. Responses return strictly in request order at a fixed latency.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/pipelined_main_memory_if.sv | 26 ++
 rtl/mem_resp_pipe.sv | 44 ++++
 rtl/pipelined_main_memory.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and width helpers for the pipelined main memory.
// Imported by the interface, the response pipe and the top.
package mem_pkg;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int offset_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam int RESP_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       valid;
        logic                       error;
        logic [RESP_DATA_WIDTH-1:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/pipelined_main_memory_if.sv
// Request/response bus of the main memory.
// master = requester (fetch / load-store), slave = memory.
interface pipelined_main_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    reqValid;
    logic                    reqReady;
    logic                    reqWrite;
    logic [ADDR_WIDTH-1:0]   reqAddr;
    logic [DATA_WIDTH-1:0]   reqWdata;
    logic [DATA_WIDTH/8-1:0] reqByteEn;
    logic                    respValid;
    logic [DATA_WIDTH-1:0]   respRdata;
    logic                    respError;

    modport master (
        output reqValid, reqWrite, reqAddr, reqWdata, reqByteEn,
        input  reqReady, respValid, respRdata, respError
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqWdata, reqByteEn,
        output reqReady, respValid, respRdata, respError
    );
endinterface

// File: rtl/mem_resp_pipe.sv
// Fixed-length delay line for memory responses.
// Only the valid bits are reset; the payload simply follows.
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int  STAGES = 1,
    parameter type resp_t = mem_resp_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  resp_t din,
    output resp_t dout
);

    logic [STAGES-1:0] valid_r;
    resp_t             data_r [STAGES];

    // Valid bits shift with async clear so in-flight responses vanish on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else begin
            valid_r[0] <= din.valid;
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    // Payload shift register, no reset needed
    always_ff @(posedge clk) begin
        data_r[0] <= din;
        for (int i = 1; i < STAGES; i++) begin
            data_r[i] <= data_r[i-1];
        end
    end

    // Recombine the last stage with its reset-aware valid bit
    always_comb begin
        dout       = data_r[STAGES-1];
        dout.valid = valid_r[STAGES-1];
    end

endmodule

// File: rtl/pipelined_main_memory.sv
// Single-port main memory with byte-lane writes, fixed read latency,
// address checking and optional zero-fill after reset.
module pipelined_main_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 0,
    parameter     INIT_FILE      = ""
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_main_memory_if.slave  bus
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int OFF   = offset_bits(DATA_WIDTH);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BPW - 1);
    localparam mem_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    typedef struct packed {
        logic                  valid;
        logic                  error;
        logic [DATA_WIDTH-1:0] rdata;
    } resp_t;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

    mem_state_e            state_r;
    logic [CNT_W-1:0]      clear_cnt_r;
    logic                  ready_r;
    logic                  resp0_valid_r;
    logic                  rd_err_r;
    logic [DATA_WIDTH-1:0] rd_data_r;

    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [IDX_W-1:0]      mem_idx_s;
    logic                  misalign_s;
    logic                  range_err_s;
    logic                  req_err_s;
    logic                  accept_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic                  clear_we_s;
    resp_t                 stage0_s;
    resp_t                 pipe_out_s;

    // Request decode: word index, address checks and access enables
    always_comb begin
        word_idx_s  = bus.reqAddr >> OFF;
        mem_idx_s   = word_idx_s[IDX_W-1:0];
        misalign_s  = |(bus.reqAddr & OFF_MASK);
        range_err_s = (word_idx_s >= ADDR_WIDTH'(DEPTH_WORDS));
        req_err_s   = misalign_s || range_err_s;
        accept_s    = bus.reqValid && ready_r;
        wr_en_s     = accept_s && bus.reqWrite && !req_err_s;
        rd_en_s     = !bus.reqWrite && !req_err_s;
        clear_we_s  = rst_n && (state_r == CLEAR) && !clear_cnt_r[CNT_W-1];
    end

    // Control FSM: zero-fill sequencing and the ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RESET_STATE;
            clear_cnt_r <= '0;
            ready_r     <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    if (clear_cnt_r == CNT_W'(DEPTH_WORDS)) begin
                        state_r <= READY;
                        ready_r <= 1'b1;
                    end else begin
                        clear_cnt_r <= clear_cnt_r + CNT_W'(1);
                        ready_r     <= 1'b0;
                    end
                end
                READY: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= READY;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: zero-fill has priority, otherwise byte-lane merge
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[clear_cnt_r[IDX_W-1:0]] <= '0;
        end else if (wr_en_s) begin
            for (int i = 0; i < BPW; i++) begin
                if (bus.reqByteEn[i]) begin
                    mem_r[mem_idx_s][8*i +: 8] <= bus.reqWdata[8*i +: 8];
                end
            end
        end
    end

    // First response stage: array sampled on the accepting edge
    always_ff @(posedge clk) begin
        if (accept_s) begin
            rd_err_r  <= req_err_s;
            rd_data_r <= rd_en_s ? mem_r[mem_idx_s] : '0;
        end
    end

    // Valid bit of the first response stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid_r <= 1'b0;
        end else begin
            resp0_valid_r <= accept_s;
        end
    end

    always_comb begin
        stage0_s       = '0;
        stage0_s.valid = resp0_valid_r;
        stage0_s.error = rd_err_r;
        stage0_s.rdata = rd_data_r;
    end

    if (READ_LATENCY > 1) begin : g_pipe
        mem_resp_pipe #(
            .STAGES (READ_LATENCY - 1),
            .resp_t (resp_t)
        ) u_resp_pipe (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (stage0_s),
            .dout  (pipe_out_s)
        );
    end else begin : g_nopipe
        assign pipe_out_s = stage0_s;
    end

    // Payload is masked when idle so outputs read zero out of reset
    assign bus.reqReady  = ready_r;
    assign bus.respValid = pipe_out_s.valid;
    assign bus.respError = pipe_out_s.valid & pipe_out_s.error;
    assign bus.respRdata = pipe_out_s.valid ? pipe_out_s.rdata : '0;

endmodule
